// File: rtl/r5p_uart_pkg.sv
// Shared types and 8N1 frame constants for the r5p UART receiver.
package r5p_uart_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned STOP_BITS = 1;
   localparam int unsigned IDX_W     = $clog2(DATA_W);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_t;

endpackage

// File: rtl/r5p_uart_fifo.sv
// First-word-fall-through receive FIFO with extra-MSB pointers.
module r5p_uart_fifo
   import r5p_uart_pkg::*;
#(
   parameter int unsigned FIFO_SIZ = 16,
   parameter int unsigned DAT_W    = DATA_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_vld,
   input  logic [DAT_W-1:0]            wr_dat,
   input  logic                        rd_rdy,
   output logic                        rd_vld,
   output logic [DAT_W-1:0]            rd_dat,
   output logic [$clog2(FIFO_SIZ):0]   cnt,
   output logic                        ovf
);

   localparam int unsigned AW = $clog2(FIFO_SIZ);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [DAT_W-1:0] mem [FIFO_SIZ];

   logic empty_c;
   logic full_c;
   logic pop_c;
   logic push_c;

   // Full/empty decode; a push into a full FIFO succeeds only alongside a pop.
   always_comb begin
      empty_c = (wr_ptr == rd_ptr);
      full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pop_c   = rd_rdy & ~empty_c;
      push_c  = wr_vld & (~full_c | pop_c);
   end

   // Pointer and overflow-pulse registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
         ovf <= wr_vld & full_c & ~pop_c;
      end
   end

   // Storage array, no reset so it maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end

   assign rd_vld = ~empty_c;
   assign rd_dat = mem[rd_ptr[AW-1:0]];
   assign cnt    = wr_ptr - rd_ptr;

endmodule

// File: rtl/r5p_uart_rx.sv
// 8N1 UART receiver: synchronizer, bit-timing FSM and receive FIFO.
module r5p_uart_rx
   import r5p_uart_pkg::*;
#(
   parameter int unsigned BDR_DIV  = 234,
   parameter int unsigned FIFO_SIZ = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       uart_rxd,
   output logic                       rx_vld,
   input  logic                       rx_rdy,
   output logic [DATA_W-1:0]          rx_dat,
   output logic [$clog2(FIFO_SIZ):0]  rx_cnt,
   output logic                       err_frm,
   output logic                       err_ovf
);

   localparam int unsigned CW = $clog2(BDR_DIV);

   logic [2:0]        rxd_sync;
   logic              rxd_c;
   logic              fall_c;

   uart_state_t       state;
   uart_state_t       state_nxt;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_nxt;
   logic [IDX_W-1:0]  bit_idx;
   logic [IDX_W-1:0]  bit_idx_nxt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic              push_c;
   logic              frm_c;

   // Two-flop synchronizer plus a third flop for falling-edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) rxd_sync <= '1;
      else        rxd_sync <= {rxd_sync[1:0], uart_rxd};
   end

   assign rxd_c  = rxd_sync[1];
   assign fall_c = rxd_sync[2] & ~rxd_sync[1];

   // Receiver state, bit timer, bit index, shift register and framing pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         err_frm <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shreg   <= shreg_nxt;
         err_frm <= frm_c;
      end
   end

   // Next-state logic; every sample is taken when the down-counter reaches zero.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      push_c      = 1'b0;
      frm_c       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fall_c) begin
               state_nxt = ST_START;
               cnt_nxt   = CW'(BDR_DIV/2 - 1);
            end
         end
         ST_START: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CW'(1);
            end else if (!rxd_c) begin
               state_nxt   = ST_DATA;
               cnt_nxt     = CW'(BDR_DIV - 1);
               bit_idx_nxt = '0;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CW'(1);
            end else begin
               shreg_nxt = {rxd_c, shreg[DATA_W-1:1]};
               cnt_nxt   = CW'(BDR_DIV - 1);
               if (bit_idx == IDX_W'(DATA_W - 1)) state_nxt = ST_STOP;
               else                               bit_idx_nxt = bit_idx + IDX_W'(1);
            end
         end
         ST_STOP: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CW'(1);
            end else begin
               // Leave at mid stop bit so a closely following start edge is caught.
               push_c    = rxd_c;
               frm_c     = ~rxd_c;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   r5p_uart_fifo #(
      .FIFO_SIZ (FIFO_SIZ),
      .DAT_W    (DATA_W)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_vld (push_c),
      .wr_dat (shreg),
      .rd_rdy (rx_rdy),
      .rd_vld (rx_vld),
      .rd_dat (rx_dat),
      .cnt    (rx_cnt),
      .ovf    (err_ovf)
   );

endmodule

// File: doc/r5p_uart_rx.md
R5P_UART_RX -- requirements
Module: r5p_uart_rx

Interface
REQ-001 SHALL have parameter BDR_DIV, default 234 (27 MHz / 115200): clock cycles per UART bit, minimum 4.
REQ-002 SHALL have parameter FIFO_SIZ, default 16: receive FIFO depth in bytes, power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_vld  output  1  FIFO head byte valid.
REQ-007 SHALL have port rx_rdy  input  1  consumer accepts the head byte.
REQ-008 SHALL have port rx_dat  output  8  FIFO head byte.
REQ-009 SHALL have port rx_cnt  output  $clog2(FIFO_SIZ)+1  FIFO occupancy.
REQ-010 SHALL have port err_frm  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port err_ovf  output  1  one-cycle pulse: byte dropped, FIFO full.

Function
REQ-012 SHALL pass uart_rxd through a 2-flop synchronizer; a third flop provides falling-edge detection.
REQ-013 SHALL frame 8N1 only: start bit low, 8 data bits LSB first, one stop bit high.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP with one down-counter for bit timing.
REQ-015 IDLE: on synchronized falling edge -> START, counter = BDR_DIV/2-1; a line held low SHALL NOT retrigger.
REQ-016 START: at counter 0 sample the line; low -> DATA, counter = BDR_DIV-1, bit index = 0; high -> IDLE (glitch rejected, no error).
REQ-017 DATA: at each counter 0 shift the sample into bit 7 of the shift register, reload BDR_DIV-1; after the 8th sample -> STOP.
REQ-018 STOP: at counter 0 sample; high -> push byte, -> IDLE; low -> err_frm pulse, byte discarded, -> IDLE.
REQ-019 Return to IDLE SHALL occur at mid stop bit, so a start bit half a bit later is still captured.
REQ-020 FIFO SHALL be first-word-fall-through: rx_vld = not empty, rx_dat = head byte, pop on rx_vld & rx_rdy.
REQ-021 Pushed byte SHALL appear on rx_dat with rx_vld high the cycle after the stop-bit sample.
REQ-022 Push when full without simultaneous pop: byte dropped, err_ovf pulse, FIFO contents unchanged.
REQ-023 Push and pop in the same cycle when full SHALL both succeed; rx_cnt stays FIFO_SIZ.
REQ-024 rx_rdy with rx_vld low SHALL be ignored; rx_cnt SHALL never underflow.
REQ-025 Read/write pointers SHALL be $clog2(FIFO_SIZ)+1 bits wide and wrap modulo 2*FIFO_SIZ; full/empty are decoded from the MSB comparison.
REQ-026 err_frm and err_ovf SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-027 rst_n low at a clk edge SHALL set FSM = IDLE, counters = 0, synchronizer flops = 1, FIFO pointers = 0.
REQ-028 During and after reset: rx_vld = 0, rx_cnt = 0, err_frm = 0, err_ovf = 0; rx_dat value is don't-care.
REQ-029 Reset mid-frame SHALL abort the frame with no error pulse; the first falling edge after release starts a new frame.

Structure
REQ-030 Package r5p_uart_pkg SHALL hold the FSM state enum and the 8N1 frame constants (data width 8, stop bits 1).
REQ-031 The FIFO SHALL be sub-module r5p_uart_fifo (parameters FIFO_SIZ and data width 8), inferable as Gowin RAM16SDP4 at depth 16.
REQ-032 Total RTL SHALL remain within 120-400 lines.

Verification (bench BDR_DIV=8, FIFO_SIZ=4)
REQ-033 Send 0xA5 -> rx_vld rises 1 cycle after the mid-stop sample; rx_dat = 0xA5; rx_cnt = 1; no error pulses.
REQ-034 Low glitch of 3 cycles on an idle line -> FSM returns to IDLE; no push, no errors.
REQ-035 Frame 0x3C with stop bit low -> one err_frm pulse; rx_cnt stays 0; the next frame 0x5A is received correctly.
REQ-036 Send 0x01..0x05 with rx_rdy = 0 -> rx_cnt = 4, one err_ovf pulse on 0x05; popping yields 0x01..0x04 in order.
REQ-037 FIFO full, pop coinciding with push of 0x77 -> rx_cnt stays 4; 0x77 is read last; no err_ovf.
REQ-038 rst_n low during data bit 4 of 0xFF -> no push, no errors; a following frame 0x81 is received correctly.
